// File: rtl/nim_pkg.sv
// rtl/nim_pkg.sv - shared state type and heap-load helper for the nim engine
package nim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_TAKING = 2'd2,
      ST_OVER   = 2'd3
   } nim_state_e;

   function automatic int init_heap(input int row, input int max_v);
      return (2 * row + 1 < max_v) ? 2 * row + 1 : max_v;
   endfunction

endpackage

// File: rtl/score_counter.sv
// rtl/score_counter.sv - saturating up counter with synchronous clear (clear wins)
module score_counter #(
   parameter int MAX = 9,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && cnt_q != W'(MAX))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/nim_engine.sv
// rtl/nim_engine.sv - multi-player nim referee: heaps, turn rotation, winner and scores
module nim_engine
   import nim_pkg::*;
#(
   parameter int NUM_ROWS    = 4,
   parameter int MAX_ITEMS   = 8,
   parameter int NUM_PLAYERS = 2,
   parameter int MISERE      = 1,
   parameter int SCORE_MAX   = 9,
   localparam int CW = $clog2(MAX_ITEMS + 1),
   localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int SW = $clog2(SCORE_MAX + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      new_game,
   input  logic                      clr_scores,
   input  logic [NUM_ROWS-1:0]       take,
   input  logic                      commit,
   output logic [NUM_ROWS*CW-1:0]    heap_cnt,
   output logic [PW-1:0]             player_turn,
   output logic [RW-1:0]             sel_row,
   output logic                      row_locked,
   output logic                      illegal,
   output logic                      game_over,
   output logic [PW-1:0]             winner,
   output logic [NUM_PLAYERS*SW-1:0] score
);

   nim_state_e       state_q, state_d;
   logic [CW-1:0]    heap_q [NUM_ROWS];
   logic [CW-1:0]    heap_d [NUM_ROWS];
   logic [CW-1:0]    heap_take [NUM_ROWS];
   logic [PW-1:0]    turn_q, turn_d, winner_q, winner_d, next_turn;
   logic [RW-1:0]    sel_q, sel_d, take_row;
   logic             locked_q, locked_d, illegal_q, illegal_d;
   logic             take_any, take_ok, all_zero;
   logic [NUM_PLAYERS-1:0] score_inc;

   assign next_turn = (turn_q == PW'(NUM_PLAYERS - 1)) ? '0 : turn_q + PW'(1);

   // Only the lowest requested row counts; descending scan lets it overwrite higher ones.
   always_comb begin
      take_any = 1'b0;
      take_row = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (take[r]) begin
            take_any = 1'b1;
            take_row = RW'(r);
         end
      end
   end

   // Heaps after this cycle's take, so a same-cycle commit sees the updated counts.
   always_comb begin
      take_ok = 1'b0;
      if (take_any && heap_q[take_row] != '0) begin
         if (state_q == ST_SELECT)
            take_ok = 1'b1;
         else if (state_q == ST_TAKING && take_row == sel_q)
            take_ok = 1'b1;
      end
      all_zero = 1'b1;
      for (int r = 0; r < NUM_ROWS; r++) begin
         heap_take[r] = heap_q[r];
         if (take_ok && take_row == RW'(r))
            heap_take[r] = heap_q[r] - CW'(1);
         if (heap_take[r] != '0)
            all_zero = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      if (new_game) begin
         state_d = ST_SELECT;
      end else begin
         case (state_q)
            ST_SELECT: if (take_ok) state_d = ST_TAKING;
            ST_TAKING: if (commit)  state_d = all_zero ? ST_OVER : ST_SELECT;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      heap_d    = heap_q;
      turn_d    = turn_q;
      sel_d     = sel_q;
      locked_d  = locked_q;
      illegal_d = 1'b0;
      winner_d  = winner_q;
      score_inc = '0;
      if (new_game) begin
         for (int r = 0; r < NUM_ROWS; r++)
            heap_d[r] = CW'(init_heap(r, MAX_ITEMS));
         turn_d   = '0;
         sel_d    = '0;
         locked_d = 1'b0;
         winner_d = '0;
      end else begin
         case (state_q)
            ST_SELECT: begin
               heap_d    = heap_take;
               illegal_d = (take_any && !take_ok) || commit;
               if (take_ok) begin
                  sel_d    = take_row;
                  locked_d = 1'b1;
               end
            end
            ST_TAKING: begin
               heap_d    = heap_take;
               illegal_d = take_any && !take_ok;
               if (commit) begin
                  if (all_zero) begin
                     winner_d            = (MISERE != 0) ? next_turn : turn_q;
                     score_inc[winner_d] = 1'b1;
                  end else begin
                     turn_d   = next_turn;
                     locked_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         for (int r = 0; r < NUM_ROWS; r++)
            heap_q[r] <= '0;
         turn_q    <= '0;
         sel_q     <= '0;
         locked_q  <= 1'b0;
         illegal_q <= 1'b0;
         winner_q  <= '0;
      end else begin
         state_q   <= state_d;
         heap_q    <= heap_d;
         turn_q    <= turn_d;
         sel_q     <= sel_d;
         locked_q  <= locked_d;
         illegal_q <= illegal_d;
         winner_q  <= winner_d;
      end
   end

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_heap
      assign heap_cnt[r*CW +: CW] = heap_q[r];
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
      score_counter #(.MAX(SCORE_MAX), .W(SW)) u_score (
         .clk   (clk),
         .rst_n (reset),
         .clr   (clr_scores),
         .inc   (score_inc[p]),
         .cnt   (score[p*SW +: SW])
      );
   end

   assign player_turn = turn_q;
   assign sel_row     = sel_q;
   assign row_locked  = locked_q;
   assign illegal     = illegal_q;
   assign game_over   = (state_q == ST_OVER);
   assign winner      = winner_q;

endmodule

// File: doc/nim_engine.md
NIM_ENGINE -- requirements
Module: nim_engine

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 4, number of heaps (1..8).
REQ-002 SHALL have parameter MAX_ITEMS, default 8, capacity per heap (1..15).
REQ-003 SHALL have parameter NUM_PLAYERS, default 2, players in rotation (2..4).
REQ-004 SHALL have parameter MISERE, default 1; 1 means the last taker loses, 0 means the last taker wins.
REQ-005 SHALL have parameter SCORE_MAX, default 9, the score saturation value.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-008 new_game  in  1  one-cycle pulse; loads heaps and starts a game.
REQ-009 clr_scores  in  1  one-cycle pulse; zeroes all scores.
REQ-010 take  in  NUM_ROWS  one-cycle debounced pulses; bit r requests removal of one item from heap r.
REQ-011 commit  in  1  one-cycle pulse; ends the current player's turn.
REQ-012 heap_cnt  out  NUM_ROWS*CW  packed heap counts, row r at bits [r*CW +: CW]; CW = $clog2(MAX_ITEMS+1).
REQ-013 player_turn  out  PW  current player index; PW = max(1,$clog2(NUM_PLAYERS)).
REQ-014 sel_row  out  $clog2(NUM_ROWS) (min 1)  row locked for this turn, valid when row_locked=1.
REQ-015 row_locked  out  1  a take has occurred this turn.
REQ-016 illegal  out  1  one-cycle pulse on an ignored take or commit.
REQ-017 game_over  out  1  high in state OVER.
REQ-018 winner  out  PW  winning player, valid when game_over=1.
REQ-019 score  out  NUM_PLAYERS*SW  packed saturating scores; SW = $clog2(SCORE_MAX+1).

Function
REQ-020 SHALL implement FSM states IDLE, SELECT, TAKING, OVER; all outputs registered; every effect is visible on the cycle after the input pulse.
REQ-021 new_game in any state SHALL load heap r with min(2r+1, MAX_ITEMS), set player_turn=0, clear row_locked, and go to SELECT; it has priority over take and commit in the same cycle.
REQ-022 In SELECT, take bit r with heap_cnt[r]>0 SHALL decrement heap r, set sel_row=r and row_locked=1, and go to TAKING.
REQ-023 When several take bits are set in one cycle, only the lowest-indexed bit SHALL be considered.
REQ-024 In TAKING, a take on sel_row with count>0 SHALL decrement that heap; a take on another row or on an empty sel_row SHALL be ignored and pulse illegal.
REQ-025 A take on an empty heap in SELECT SHALL be ignored and pulse illegal.
REQ-026 A commit in SELECT SHALL be ignored and pulse illegal.
REQ-027 A take and a commit in the same cycle in TAKING SHALL apply the take (if legal), then the commit evaluates the updated heaps.
REQ-028 On a commit in TAKING with all heaps then zero, the block SHALL go to OVER.
REQ-029 On entering OVER, winner SHALL be the next player (MISERE=1) or the current player (MISERE=0), and that player's score SHALL increment, saturating at SCORE_MAX.
REQ-030 On a commit in TAKING with any heap non-zero, player_turn SHALL advance modulo NUM_PLAYERS, row_locked SHALL clear, and the state SHALL return to SELECT.
REQ-031 A heap SHALL never decrement below 0.
REQ-032 In IDLE and OVER, take and commit SHALL be ignored without an illegal pulse.
REQ-033 clr_scores SHALL zero the scores in any state; if a score increment occurs in the same cycle, clr_scores SHALL win.
REQ-034 Scores SHALL persist across new_game.

Reset
REQ-035 reset=0 SHALL immediately force: state IDLE, all heaps 0, player_turn 0, sel_row 0, row_locked 0, illegal 0, game_over 0, winner 0, all scores 0.
REQ-036 Reset asserted mid-turn SHALL discard the turn completely; after release the block stays in IDLE until new_game.

Structure
REQ-037 Package nim_pkg SHALL hold the state enum type and a function init_heap(row, max) that returns min(2*row+1, max).
REQ-038 Sub-module score_counter (a saturating up counter with clear, parameter MAX) SHALL be instantiated NUM_PLAYERS times.

Verification (defaults)
REQ-039 Reset, then new_game -> heap_cnt = {7,5,3,1} (rows 3..0), player_turn=0, state SELECT.
REQ-040 take=0001, then take=0010 -> heap0=0, the second take is ignored with one illegal pulse, heap1 stays 3.
REQ-041 take=0110 in a single cycle -> only heap1 decrements (3->2), sel_row=1.
REQ-042 Players empty every heap, and player 1 commits the final take -> game_over=1, winner=0, score0=1; 10 such wins -> score0 holds at 9.
REQ-043 Reset pulled low mid-TAKING with heap2=4 -> all heaps 0 and state IDLE at once; a commit after release produces no effect and no illegal pulse.
REQ-044 clr_scores and a winning commit in the same cycle -> game_over=1 and all scores 0.
